// File: rtl/pkt_ingest.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pkt_ingest                                                    |
// | Purpose  : Takes Ethernet frames from an Avalon-ST RX source and writes  |
// |            them word by word into a circular buffer through an Avalon-MM |
// |            write master. Good frames are committed and described by a    |
// |            descriptor. Errored, oversize, truncated or non-fitting       |
// |            frames are discarded by rewinding the write pointer.          |
// | Ports    : clk, reset (sync, active-low)                                 |
// |            asi_*          - frame stream in (data, valid/ready, sop/eop, |
// |                             empty, error)                                |
// |            ts_*           - free-running timestamp in                    |
// |            consumed_ptr   - consumer release pointer (words, wrap bit)   |
// |            avm_*          - single-word write master                     |
// |            pkt_*          - descriptor out, valid/ack handshake          |
// |            pkt_count, drop_count - committed / discarded frame counters  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pkt_ingest #(
   parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
   parameter int          BUF_WORDS     = 1024,
   parameter int          MAX_PKT_WORDS = 380,
   localparam int         AW            = $clog2(BUF_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   asi_data,
   input  logic          asi_valid,
   output logic          asi_ready,
   input  logic          asi_sop,
   input  logic          asi_eop,
   input  logic [1:0]    asi_empty,
   input  logic          asi_error,
   input  logic [31:0]   ts_seconds,
   input  logic [31:0]   ts_nanoseconds,
   input  logic [AW:0]   consumed_ptr,
   output logic [31:0]   avm_address,
   output logic [31:0]   avm_writedata,
   output logic          avm_write,
   output logic [15:0]   avm_burstcount,
   input  logic          avm_waitrequest,
   output logic          pkt_valid,
   input  logic          pkt_ack,
   output logic [31:0]   pkt_begin,
   output logic [31:0]   pkt_end,
   output logic [15:0]   pkt_len,
   output logic [31:0]   pkt_seconds,
   output logic [31:0]   pkt_nanoseconds,
   output logic [31:0]   pkt_count,
   output logic [31:0]   drop_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_FLUSH  = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_DROP   = 3'd4;

   localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   RING_FULL = (AW+1)'(BUF_WORDS);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);
   localparam logic [15:0]   MAX_CNT   = 16'(MAX_PKT_WORDS);

   logic [2:0]  state_q, state_d;
   logic [AW:0] wr_q, wr_d, commit_q, commit_d, cons_q;
   logic [15:0] cnt_q, cnt_d;
   logic        avm_write_q, avm_write_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] begin_q, begin_d, end_q, end_d;
   logic [31:0] sec_q, sec_d, ns_q, ns_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  empty_q, empty_d;
   logic        err_q, err_d;
   logic [31:0] pktc_q, pktc_d, dropc_q;
   logic [1:0]  drop_inc;

   logic        w_accept, w_wr_done, w_full_sop, w_full_wr;
   logic        w_start, w_wr_en;
   logic [AW:0] w_wr_at;

   function automatic logic [31:0] word_addr(input logic [AW-1:0] idx);
      word_addr = BUF_BASE + 32'({idx, 2'b00});
   endfunction

   // The pending write (if any) retires this cycle, so a new one may be issued.
   assign w_wr_done = !avm_write_q || !avm_waitrequest;
   assign asi_ready = ((state_q == S_IDLE || state_q == S_WRITE) && w_wr_done)
                      || (state_q == S_DROP);
   assign w_accept  = asi_valid && asi_ready;

   // A new frame always starts at the committed pointer, so its fullness is
   // judged from there; mid-frame fullness uses the speculative pointer.
   // cons_q is last cycle's consumed_ptr.
   assign w_full_sop = (commit_q - cons_q) == RING_FULL;
   assign w_full_wr  = (wr_q - cons_q) == RING_FULL;

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      commit_d    = commit_q;
      cnt_d       = cnt_q;
      avm_write_d = avm_write_q && avm_waitrequest;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      begin_d     = begin_q;
      end_d       = end_q;
      len_d       = len_q;
      sec_d       = sec_q;
      ns_d        = ns_q;
      empty_d     = empty_q;
      err_d       = err_q;
      pktc_d      = pktc_q;
      drop_inc    = 2'd0;
      w_start     = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_at     = wr_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept && asi_sop) w_start = 1'b1;
         end
         S_WRITE: begin
            if (w_accept) begin
               if (asi_sop) begin
                  // Truncated frame: abandon it and restart on this beat.
                  drop_inc = 2'd1;
                  w_start  = 1'b1;
               end else if (w_full_wr || cnt_q == MAX_CNT) begin
                  wr_d     = commit_q;
                  drop_inc = 2'd1;
                  state_d  = asi_eop ? S_IDLE : S_DROP;
               end else begin
                  w_wr_en = 1'b1;
                  wr_d    = wr_q + PTR_ONE;
                  cnt_d   = cnt_q + 16'd1;
                  if (asi_eop) state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (w_wr_done) begin
               if (err_q) begin
                  wr_d     = commit_q;
                  drop_inc = 2'd1;
                  state_d  = S_IDLE;
               end else begin
                  end_d   = word_addr(wr_q[AW-1:0] - IDX_ONE);
                  len_d   = {cnt_q[13:0], 2'b00} - {14'd0, empty_q};
                  state_d = S_COMMIT;
               end
            end
         end
         S_COMMIT: begin
            if (pkt_ack) begin
               commit_d = wr_q;
               pktc_d   = pktc_q + 32'd1;
               state_d  = S_IDLE;
            end
         end
         S_DROP: begin
            if (w_accept) begin
               if (asi_sop)      w_start = 1'b1;
               else if (asi_eop) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (w_start) begin
         wr_d = commit_q;
         if (w_full_sop) begin
            drop_inc = drop_inc + 2'd1;
            state_d  = asi_eop ? S_IDLE : S_DROP;
         end else begin
            w_wr_en = 1'b1;
            w_wr_at = commit_q;
            wr_d    = commit_q + PTR_ONE;
            cnt_d   = 16'd1;
            begin_d = word_addr(commit_q[AW-1:0]);
            sec_d   = ts_seconds;
            ns_d    = ts_nanoseconds;
            state_d = asi_eop ? S_FLUSH : S_WRITE;
         end
      end

      // Error/empty are only meaningful on the EOP beat, which is the last
      // written beat of the frame and therefore the one that sticks.
      if (w_wr_en) begin
         avm_write_d = 1'b1;
         addr_d      = word_addr(w_wr_at[AW-1:0]);
         wdata_d     = asi_data;
         err_d       = asi_error && asi_eop;
         empty_d     = asi_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_q        <= '0;
         commit_q    <= '0;
         cons_q      <= '0;
         cnt_q       <= '0;
         avm_write_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         begin_q     <= '0;
         end_q       <= '0;
         len_q       <= '0;
         sec_q       <= '0;
         ns_q        <= '0;
         empty_q     <= '0;
         err_q       <= 1'b0;
         pktc_q      <= '0;
         dropc_q     <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         commit_q    <= commit_d;
         cons_q      <= consumed_ptr;
         cnt_q       <= cnt_d;
         avm_write_q <= avm_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         begin_q     <= begin_d;
         end_q       <= end_d;
         len_q       <= len_d;
         sec_q       <= sec_d;
         ns_q        <= ns_d;
         empty_q     <= empty_d;
         err_q       <= err_d;
         pktc_q      <= pktc_d;
         dropc_q     <= dropc_q + {30'd0, drop_inc};
      end
   end

   assign avm_address     = addr_q;
   assign avm_writedata   = wdata_q;
   assign avm_write       = avm_write_q;
   assign avm_burstcount  = 16'd1;
   assign pkt_valid       = (state_q == S_COMMIT);
   assign pkt_begin       = begin_q;
   assign pkt_end         = end_q;
   assign pkt_len         = len_q;
   assign pkt_seconds     = sec_q;
   assign pkt_nanoseconds = ns_q;
   assign pkt_count       = pktc_q;
   assign drop_count      = dropc_q;

endmodule
`default_nettype wire
